child_rr_sched: RTL and testbench



---
 rtl/child_sched_pkg.sv | 14 +
 rtl/child_rr_sched_if.sv | 28 ++
 rtl/child_rr_sched_rr_pick.sv | 30 +++
 rtl/child_rr_sched.sv | 113 +++++++++++
 tb/tb_child_rr_sched.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/child_sched_pkg.sv
// Shared types and defaults for root-level child schedulers.
// Imported by the interface, the picker and the scheduler top.
package child_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      GAP
   } sched_state_e;

   localparam int N_REQ_DEF    = 5;
   localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/child_rr_sched_if.sv
// Request/grant bundle between the child instances and the scheduler.
// master = scheduler side, slave = child side.
interface child_rr_sched_if
   import child_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int ID_W  = $clog2(N_REQ)
) ();

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] done;
   logic [N_REQ-1:0] gnt;
   logic [ID_W-1:0]  gnt_id;
   logic             busy;
   logic             timeout;
   logic [7:0]       grant_count;

   modport master (
      input  req, done,
      output gnt, gnt_id, busy, timeout, grant_count
   );

   modport slave (
      output req, done,
      input  gnt, gnt_id, busy, timeout, grant_count
   );

endinterface

// File: rtl/child_rr_sched_rr_pick.sv
// Round-robin next-winner search starting just above 'last'.
// 'last' itself is reached only after every other index, so it wins only alone.
module rr_pick
   import child_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last,
   output logic             valid,
   output logic [ID_W-1:0]  idx
);

   // Scan far-to-near so the nearest set bit after last is assigned last.
   always_comb begin
      int j;
      valid = 1'b0;
      idx   = '0;
      j     = 0;
      for (int k = N_REQ; k >= 1; k--) begin
         j = (int'(last) + k) % N_REQ;
         if (req[j]) begin
            valid = 1'b1;
            idx   = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/child_rr_sched.sv
// Round-robin grant of one shared resource among the root's children.
// Grant held until done of the grantee or MAX_HOLD cycles, then one gap cycle.
module child_rr_sched
   import child_sched_pkg::*;
#(
   parameter int N_REQ    = N_REQ_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int ID_W     = $clog2(N_REQ)
) (
   input logic             clk,
   input logic             rst_n,
   child_rr_sched_if.master bus
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);

   sched_state_e     state_q, state_nx;
   logic [N_REQ-1:0] gnt_q, gnt_nx;
   logic [ID_W-1:0]  id_q, id_nx;
   logic [ID_W-1:0]  last_q, last_nx;
   logic             busy_q, busy_nx;
   logic             to_q, to_nx;
   logic [7:0]       cnt_q, cnt_nx;
   logic [HW-1:0]    hold_q, hold_nx;
   logic             pk_valid;
   logic [ID_W-1:0]  pk_idx;
   logic             done_hit;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req   (bus.req),
      .last  (last_q),
      .valid (pk_valid),
      .idx   (pk_idx)
   );

   assign done_hit = |(bus.done & gnt_q);

   // State and output registers; reset drops the grant immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         id_q    <= '0;
         last_q  <= ID_W'(N_REQ - 1);
         busy_q  <= 1'b0;
         to_q    <= 1'b0;
         cnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_nx;
         gnt_q   <= gnt_nx;
         id_q    <= id_nx;
         last_q  <= last_nx;
         busy_q  <= busy_nx;
         to_q    <= to_nx;
         cnt_q   <= cnt_nx;
         hold_q  <= hold_nx;
      end
   end

   // Next-state and next-output logic; done wins over timeout.
   always_comb begin
      state_nx = state_q;
      gnt_nx   = gnt_q;
      id_nx    = id_q;
      last_nx  = last_q;
      busy_nx  = busy_q;
      to_nx    = 1'b0;
      cnt_nx   = cnt_q;
      hold_nx  = hold_q;
      unique case (state_q)
         IDLE: begin
            if (pk_valid) begin
               gnt_nx   = N_REQ'(1) << pk_idx;
               id_nx    = pk_idx;
               busy_nx  = 1'b1;
               hold_nx  = '0;
               cnt_nx   = cnt_q + 8'd1;
               state_nx = GRANT;
            end
         end
         GRANT: begin
            if (done_hit || hold_q == HOLD_LAST) begin
               gnt_nx   = '0;
               busy_nx  = 1'b0;
               last_nx  = id_q;
               to_nx    = !done_hit;
               state_nx = GAP;
            end else if (hold_q != HOLD_SAT) begin
               hold_nx = hold_q + 1'b1;
            end
         end
         GAP: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign bus.gnt         = gnt_q;
   assign bus.gnt_id      = id_q;
   assign bus.busy        = busy_q;
   assign bus.timeout     = to_q;
   assign bus.grant_count = cnt_q;

endmodule

// File: tb/tb_child_rr_sched.sv
// Directed bench for child_rr_sched: grants, fairness, timeout, reset, wrap.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_child_rr_sched;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;

   child_rr_sched_if #(.N_REQ(5)) bus ();

   child_rr_sched #(
      .N_REQ    (5),
      .MAX_HOLD (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      bus.req  = '0;
      bus.done = '0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_gnt(input int id, output int lat);
      lat = 0;
      while (!bus.busy && lat < 40) begin
         tick();
         lat++;
      end
      chk("gnt_seen", 32'(bus.busy), 32'd1);
      chk("gnt_id", 32'(bus.gnt_id), 32'(id));
      chk("gnt_vec", 32'(bus.gnt), 32'd1 << id);
   endtask

   // Structural invariants sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("inv_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
         chk("inv_busy", 32'(bus.busy), 32'(bus.gnt != 0));
         if (bus.busy)
            chk("inv_id", 32'(bus.gnt), 32'd1 << bus.gnt_id);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int ord [6];
      n_vec    = 0;
      n_bad    = 0;
      rst_n    = 1'b0;
      bus.req  = '0;
      bus.done = '0;
      #12;
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_id", 32'(bus.gnt_id), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_to", 32'(bus.timeout), 32'd0);
      chk("rst_cnt", 32'(bus.grant_count), 32'd0);

      // single request
      do_reset();
      bus.req = 5'b00100;
      tick();
      chk("s_gnt", 32'(bus.gnt), 32'b00100);
      chk("s_id", 32'(bus.gnt_id), 32'd2);
      chk("s_busy", 32'(bus.busy), 32'd1);
      bus.req = '0;
      tick();
      tick();
      bus.done = 5'b00100;
      tick();
      bus.done = '0;
      chk("s_rel", 32'(bus.gnt), 32'd0);
      chk("s_relb", 32'(bus.busy), 32'd0);
      chk("s_cnt", 32'(bus.grant_count), 32'd1);

      // round-robin fairness
      do_reset();
      ord = '{0, 1, 2, 3, 4, 0};
      bus.req = 5'b11111;
      for (int g = 0; g < 6; g++) begin
         wait_gnt(ord[g], lat);
         if (g == 0) chk("rr_lat0", 32'(lat), 32'd1);
         else        chk("rr_gap", 32'(lat), 32'd2);
         tick();
         tick();
         bus.done = 5'd1 << ord[g];
         tick();
         bus.done = '0;
         chk("rr_rel", 32'(bus.gnt), 32'd0);
      end
      chk("rr_cnt", 32'(bus.grant_count), 32'd6);
      bus.req = '0;

      // timeout with sole requester
      do_reset();
      bus.req = 5'b00010;
      tick();
      for (int i = 0; i < 16; i++) begin
         chk("to_hold", 32'(bus.gnt), 32'b00010);
         chk("to_quiet", 32'(bus.timeout), 32'd0);
         if (i < 15) tick();
      end
      tick();
      chk("to_rel", 32'(bus.gnt), 32'd0);
      chk("to_pulse", 32'(bus.timeout), 32'd1);
      tick();
      chk("to_1cyc", 32'(bus.timeout), 32'd0);
      tick();
      chk("to_regnt", 32'(bus.gnt), 32'b00010);

      // foreign done, then done on last hold cycle
      bus.done = 5'b01000;
      for (int k = 1; k <= 15; k++) begin
         tick();
         bus.done = '0;
         chk("col_hold", 32'(bus.gnt), 32'b00010);
      end
      bus.done = 5'b00010;
      bus.req  = '0;
      tick();
      bus.done = '0;
      chk("col_rel", 32'(bus.gnt), 32'd0);
      chk("col_to", 32'(bus.timeout), 32'd0);
      tick();
      chk("col_to2", 32'(bus.timeout), 32'd0);

      // asynchronous reset mid-grant
      do_reset();
      bus.req = 5'b01000;
      tick();
      chk("ar_gnt", 32'(bus.gnt), 32'b01000);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_gnt0", 32'(bus.gnt), 32'd0);
      chk("ar_busy0", 32'(bus.busy), 32'd0);
      bus.req = 5'b01001;
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      chk("ar_first", 32'(bus.gnt), 32'b00001);
      chk("ar_cnt", 32'(bus.grant_count), 32'd1);
      bus.req = '0;

      // grant counter wrap
      do_reset();
      bus.req = 5'b00001;
      for (int g = 1; g <= 257; g++) begin
         wait_gnt(0, lat);
         if (g == 255) chk("wr_255", 32'(bus.grant_count), 32'd255);
         if (g == 256) chk("wr_0", 32'(bus.grant_count), 32'd0);
         if (g == 257) chk("wr_1", 32'(bus.grant_count), 32'd1);
         bus.done = 5'b00001;
         tick();
         bus.done = '0;
      end
      bus.req = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
